// File: rtl/jtframe_i2s_tx.sv
// rtl/jtframe_i2s_tx.sv - I2S transmitter: 64 BCLK/frame stereo serialiser with integer BCLK divider
module jtframe_i2s_tx #(
    parameter int CLKDIV = 8,
    parameter int ATTEN  = 1,
    parameter int DW     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] snd_left,
    input  logic signed [DW-1:0] snd_right,
    input  logic                 sample,
    output logic                 i2s_bclk,
    output logic                 i2s_lrclk,
    output logic                 i2s_data,
    output logic                 frame
);

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

    logic [7:0]           div_cnt;
    logic [5:0]           bcnt;
    logic signed [DW-1:0] pend_l, pend_r;
    logic signed [DW-1:0] tx_l, tx_r;

    logic                 div_wrap;
    logic                 bclk_fall;
    logic [5:0]           bcnt_nxt;
    logic [4:0]           slot_pos;
    logic [DW-1:0]        cur_word;
    logic                 bit_val;

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign bclk_fall = div_wrap && i2s_bclk;
    assign bcnt_nxt  = bcnt + 6'd1;
    assign slot_pos  = bcnt_nxt[4:0];
    assign cur_word  = bcnt_nxt[5] ? tx_r : tx_l;

    // Slot position 1 carries the MSB, DW the LSB; everything else is zero padding
    always_comb begin
        bit_val = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (slot_pos == 5'(DW - i)) begin
                bit_val = cur_word[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            bcnt      <= '0;
            pend_l    <= '0;
            pend_r    <= '0;
            tx_l      <= '0;
            tx_r      <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_data  <= 1'b0;
            frame     <= 1'b0;
        end else begin
            frame <= 1'b0;
            if (sample) begin
                pend_l <= snd_left  >>> ATTEN;
                pend_r <= snd_right >>> ATTEN;
            end
            if (div_wrap) begin
                div_cnt  <= '0;
                i2s_bclk <= ~i2s_bclk;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
            // Outputs only move on BCLK falling edges so the DAC sees them stable on rising edges
            if (bclk_fall) begin
                bcnt      <= bcnt_nxt;
                i2s_lrclk <= bcnt_nxt[5];
                i2s_data  <= bit_val;
                if (bcnt_nxt == 6'd0) begin
                    tx_l  <= pend_l;
                    tx_r  <= pend_r;
                    frame <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtframe_i2s_tx.sv
// tb/tb_jtframe_i2s_tx.sv - directed scoreboard bench for jtframe_i2s_tx (ATTEN=0 and ATTEN=1 instances)
module tb_jtframe_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample = 1'b0;
    logic [15:0] snd_left = '0;
    logic [15:0] snd_right = '0;
    logic        bclk0, lr0, d0, fr0;
    logic        bclk1, lr1, d1, fr1;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    logic        prev_b[2];
    logic        last_lr[2];
    int          idx[2];
    int          pad_bad[2];
    logic [15:0] wl[2];
    logic [15:0] wc[2];

    always #5 clk = ~clk;

    jtframe_i2s_tx #(.CLKDIV(8), .ATTEN(0), .DW(16)) u_dut0 (
        .clk(clk), .rst(rst), .snd_left(snd_left), .snd_right(snd_right), .sample(sample),
        .i2s_bclk(bclk0), .i2s_lrclk(lr0), .i2s_data(d0), .frame(fr0)
    );

    jtframe_i2s_tx #(.CLKDIV(8), .ATTEN(1), .DW(16)) u_dut1 (
        .clk(clk), .rst(rst), .snd_left(snd_left), .snd_right(snd_right), .sample(sample),
        .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_data(d1), .frame(fr1)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sra1(input logic [15:0] x);
        return {x[15], x[15:1]};
    endfunction

    function automatic logic [15:0] ramp_l(input int e);
        return 16'(e * 37);
    endfunction

    function automatic logic [15:0] ramp_r(input int e);
        return 16'(32'hFFFF - e);
    endfunction

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        q0.push_back({l, r});
        q1.push_back({sra1(l), sra1(r)});
    endtask

    // Decode one instance's stream purely from LRCLK transitions seen on BCLK rising edges
    task automatic mon_step(input int g, input logic b, input logic lr, input logic d);
        int          sz;
        logic [31:0] e;
        if (b && !prev_b[g]) begin
            if (lr != last_lr[g]) idx[g] = 0;
            else                  idx[g] = idx[g] + 1;
            last_lr[g] = lr;
            if (idx[g] >= 1 && idx[g] <= 16) wc[g] = {wc[g][14:0], d};
            else if (d)                      pad_bad[g] = pad_bad[g] + 1;
            if (idx[g] == 31 && !lr) wl[g] = wc[g];
            if (idx[g] == 31 && lr) begin
                sz = (g == 0) ? q0.size() : q1.size();
                checks++;
                assert (sz > 0) else begin
                    errors++;
                    $error("FAIL u%0d_underflow: observed frame %h with no expected entry", g, {wl[g], wc[g]});
                end
                if (sz > 0) begin
                    e = (g == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("u%0d_frame_lr", g), {wl[g], wc[g]}, e);
                end
                chk($sformatf("u%0d_padding", g), 32'(pad_bad[g]), 32'd0);
                pad_bad[g] = 0;
            end
        end
        prev_b[g] = b;
    endtask

    always begin
        @(negedge clk);
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                prev_b[g]  = 1'b0;
                last_lr[g] = 1'b0;
                idx[g]     = 0;
                pad_bad[g] = 0;
                wl[g]      = '0;
                wc[g]      = '0;
            end
        end else begin
            mon_step(0, bclk0, lr0, d0);
            mon_step(1, bclk1, lr1, d1);
        end
    end

    task automatic wait_cyc(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic strobe(input int edge_no, input logic [15:0] l, input logic [15:0] r);
        wait_cyc(edge_no - 1);
        snd_left  = l;
        snd_right = r;
        sample    = 1'b1;
        @(negedge clk);
        sample    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        push(16'h0000, 16'h0000);
        push(16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        chk("rst_bclk", bclk0, 1'b0);
        chk("rst_lrclk", lr0, 1'b0);
        chk("rst_data", d0, 1'b0);
        chk("rst_frame", fr0, 1'b0);
        rst = 1'b0;

        wait_cyc(7);    chk("bclk_c7", bclk0, 1'b0);
        wait_cyc(8);    chk("bclk_c8", bclk0, 1'b1);
        wait_cyc(15);   chk("bclk_c15", bclk0, 1'b1);
        wait_cyc(16);   chk("bclk_c16", bclk0, 1'b0);
        wait_cyc(511);  chk("lr_c511", lr0, 1'b0);
        wait_cyc(512);  chk("lr_c512", lr0, 1'b1);
        wait_cyc(1023); chk("lr_c1023", lr0, 1'b1); chk("frame_c1023", fr0, 1'b0);
        wait_cyc(1024); chk("lr_c1024", lr0, 1'b0); chk("frame_c1024", fr0, 1'b1);
        chk("frame1_c1024", fr1, 1'b1);
        wait_cyc(1025); chk("frame_c1025", fr0, 1'b0);

        strobe(1500, 16'h8001, 16'h7FFE); push(16'h8001, 16'h7FFE);
        strobe(2500, 16'h8000, 16'h1234); push(16'h8000, 16'h1234);
        strobe(3200, 16'h1111, 16'h2222); push(16'h1111, 16'h2222);
        // Strobe coincides with the frame-4 load edge: it must land in frame 5
        strobe(4096, 16'hAAAA, 16'h5555); push(16'hAAAA, 16'h5555);

        push(ramp_l(6143), ramp_r(6143));
        push(ramp_l(6160), ramp_r(6160));
        wait_cyc(6099);
        for (int e = 6100; e <= 6160; e++) begin
            snd_left  = ramp_l(e);
            snd_right = ramp_r(e);
            sample    = 1'b1;
            @(negedge clk);
        end
        sample = 1'b0;

        wait_cyc(8841);
        chk("pre_rst_bclk", bclk0, 1'b1);
        chk("pre_rst_lrclk", lr0, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_bclk", bclk0, 1'b0);
        chk("async_rst_lrclk", lr0, 1'b0);
        chk("async_rst_data", d0, 1'b0);
        chk("async_rst_frame", fr0, 1'b0);
        chk("async_rst_lrclk1", lr1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push(16'h0000, 16'h0000);

        wait_cyc(7);    chk("rst2_bclk_c7", bclk0, 1'b0);
        wait_cyc(8);    chk("rst2_bclk_c8", bclk0, 1'b1);
        wait_cyc(1100);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtframe_i2s_tx.md
Name: jtframe_i2s_tx

Overview:
- Serialises the game's 16-bit stereo sound into a standard I2S stream for the board audio DAC.
- Sits directly downstream of the framework sound outputs (snd_left, snd_right, sample) and drives the I2S_BCLK, I2S_LRCLK and I2S_DATA top-level pins.
- Generates BCLK and LRCLK from a single system clock using an integer divider.
- Uses 64 BCLK per frame: 32-bit left slot, then 32-bit right slot.

Parameters:
- CLKDIV, 8: clk cycles per BCLK half-period; legal range 2..255. At 50 MHz, BCLK = 3.125 MHz and Fs = 48.83 kHz.
- ATTEN, 1: arithmetic right shift applied to each channel at capture; legal range 0..3.
- DW, 16: input sample width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- snd_left  in  DW  signed left sample
- snd_right  in  DW  signed right sample
- sample  in  1  one-clk strobe marking new valid samples; a level held high means "capture every cycle"
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_data  out  1  serial data, MSB first
- frame  out  1  one-clk pulse when a new stereo pair is loaded for transmission

Behaviour:
- Reset values (async assert, sync release): i2s_bclk=0, i2s_lrclk=0, i2s_data=0, frame=0. Internal div_cnt, bit counter bcnt[5:0], pending registers and transmit registers all clear to 0.
- Capture: on any clk with sample=1, pend_l <= snd_left>>>ATTEN and pend_r <= snd_right>>>ATTEN (sign-extending). Without a strobe, pending keeps its value.
- Divider:
  - div_cnt increments each clk.
  - When div_cnt==CLKDIV-1: div_cnt<=0 and i2s_bclk toggles.
  - First BCLK rising edge is at clk edge CLKDIV after reset release; first falling edge at 2*CLKDIV.
- Falling-edge update: on the clk where i2s_bclk toggles 1->0, all of the following happen in that same clk:
  - bcnt <= bcnt+1 (wraps 63->0); call the new value n.
  - i2s_lrclk <= n[5].
  - Slot position p = n[4:0]. If 1<=p<=DW, i2s_data <= current channel register bit (DW-p). Otherwise i2s_data <= 0.
  - The net effect: the MSB appears one BCLK after the LRCLK transition (I2S standard), and the LSB is followed by zero padding.
- Current channel register is tx_l when n[5]=0, tx_r when n[5]=1.
- Load: when n==0, tx_l <= pend_l, tx_r <= pend_r, and frame pulses high for exactly that one clk.
  - If a sample strobe lands on the same clk as a load, the load takes the pending value from before the strobe; the new sample goes out next frame.
- First frame after reset transmits zeros; the first real pair loads at the first 63->0 wrap, 64*2*CLKDIV clk after reset (1024 at default).
- Data and LRCLK are stable on every BCLK rising edge: they change only on falling edges.
- No state other than the counters, registers and outputs listed above. No backpressure: a sample arriving faster than Fs overwrites pending, and the latest value wins.
- Reset asserted mid-frame immediately forces all outputs to their reset values. The stream restarts cleanly from bcnt=0.

Test Plan:
- Reset, no samples, CLKDIV=8 -> BCLK period 16 clk, first rise at clk 8; LRCLK period 1024 clk, 50% duty; i2s_data constantly 0.
- snd_left=16'h8001, snd_right=16'h7FFE, sample pulsed once, ATTEN=0 -> after the next frame pulse, the left slot reads 1000_0000_0000_0001 starting one BCLK after LRCLK falls, followed by 16 zeros; the right slot reads 0111_1111_1111_1110.
- ATTEN=1, snd_left=16'h8000 -> left slot transmits 16'hC000, confirming sign extension.
- sample strobe on the same clk as frame -> the old pair is transmitted this frame; the new pair appears in the following frame.
- sample held high with a ramping input -> the transmitted values equal the input captured at the clk before each frame pulse.
- Assert rst for 3 clk at bcnt=40 -> outputs go to 0 asynchronously; after release, BCLK first rises at exactly CLKDIV clk.
